sync_ram_be_init: RTL and testbench
===================================

Name: sync_ram_be_init

Overview:
- Parametrised single-clock simple-dual-port synchronous RAM. Successor to the fixed 8x64 inferred RAM.
- Adds byte-enabled writes, a read-enable with a valid flag, and a selectable read-during-write mode.
- Adds a post-reset hardware clear sweep with a ready flag.
- Used as generic on-chip storage in datapath and buffer blocks.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 6, address width in bits.
- DEPTH, 64, number of words; 2 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (byte-merged) data.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write request.
- write_addr  in  ADDR_W  write address.
- data  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; bit i covers data[8i+7:8i].
- re  in  1  read request.
- read_addr  in  ADDR_W  read address.
- q  out  DATA_W  read data.
- q_valid  out  1  q holds the result of a read accepted in the previous cycle.
- init_done  out  1  clear sweep complete; requests are accepted.
- req_dropped  out  1  one-cycle pulse: a request arrived while not ready.

Behaviour:
- Reset (rst_n low, asynchronous): q=0, q_valid=0, init_done=0, req_dropped=0, FSM=INIT, clear pointer=0. Memory contents are not reset directly.
- FSM states: INIT, READY.
- INIT:
  - Each posedge writes all-zero to mem[ptr], then ptr increments.
  - The posedge that clears DEPTH-1 moves the FSM to READY and sets init_done=1.
  - init_done therefore rises on the DEPTH-th posedge after rst_n deasserts.
  - we/re are ignored; req_dropped=1 for the cycle after any posedge where (we|re) was sampled high; q and q_valid stay 0.
- READY:
  - Write: at the posedge with we=1, mem[write_addr] byte i <= data byte i for every be[i]=1. Bytes with be[i]=0 are unchanged. be=0 is a no-op.
  - Read latency is 1. At the posedge with re=1, q <= mem[read_addr] and q_valid <= 1.
  - If re=0, q holds its last value and q_valid <= 0.
  - Read-during-write, same address, same cycle:
    - RDW_MODE=0: q = word before the write.
    - RDW_MODE=1: q = old word with enabled bytes replaced by data.
  - Different addresses in the same cycle are fully independent.
  - Out of range (address >= DEPTH): write is discarded; read returns q=0 with q_valid=1.
  - req_dropped stays 0 in READY.
- Reset mid-operation: any rst_n assertion, including during INIT, returns to INIT with ptr=0. The full sweep reruns and prior contents are cleared.
- Back-to-back reads and writes are supported every cycle with no bubbles.

Optional Feature:
- Macro SYNC_RAM_OUT_REG_EN.
- Defined:
  - One extra output register stage; read latency = 2.
  - q_valid is delayed identically and stays aligned with q.
  - Stage reset value is 0. The stage is flushed (valid=0) during INIT.
  - RDW semantics are unchanged, only delayed by one cycle.
- Undefined: latency = 1, as described above.

Test Plan (defaults DATA_W=16, DEPTH=64):
- Release rst_n -> init_done=0 for 63 posedges, init_done=1 after the 64th posedge. Then re at addresses 0, 31 and 63 each give q=0x0000 with q_valid=1.
- During INIT, assert we=1, write_addr=5, data=0xBEEF, be=2'b11 -> req_dropped pulses 1 cycle. After init_done, read addr 5 -> q=0x0000.
- Byte-enable writes:
  - Write addr 10 data=0x1234 be=2'b11, then data=0xAB00 be=2'b10 -> read addr 10 gives q=0xAB34 one cycle after re, q_valid=1.
  - Next cycle with re=0 -> q_valid=0 and q holds 0xAB34.
- Same-address RDW: mem[7]=0x1111; same cycle we=1 addr 7 data=0x2222 be=2'b01, re=1 addr 7.
  - RDW_MODE=0 -> q=0x1111.
  - RDW_MODE=1 -> q=0x1122.
  - Following read -> q=0x1122 in both modes.
- DEPTH=48, ADDR_W=6: write addr 50 data=0xFFFF -> discarded. Read addr 50 -> q=0x0000 with q_valid=1. Read addr 47 -> its stored value.
- Reset mid-INIT at ptr=20, and again after writing addr 3=0x5A5A in READY -> init_done=0, sweep restarts from 0, and addr 3 later reads 0x0000. With SYNC_RAM_OUT_REG_EN defined, read results appear 2 cycles after re.

Source files
------------

// File: rtl/sync_ram_be_init.sv
// Simple-dual-port synchronous RAM with byte enables, read valid and a post-reset clear sweep.
// Define SYNC_RAM_OUT_REG_EN to add an output register stage (read latency 2).
module sync_ram_be_init #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                init_done,
  output logic                req_dropped
);

  localparam int unsigned NumBytes = DATA_W / 8;

  localparam logic [0:0] StInit  = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] q1_q, q1_d;
  logic              v1_q, v1_d;
  logic              drop_q;

  logic              wr_ok, rd_ok, rdw_hit;
  logic [DATA_W-1:0] rd_word, merged, rd_data;

  assign wr_ok   = {1'b0, write_addr} < DepthW;
  assign rd_ok   = {1'b0, read_addr} < DepthW;
  assign rd_word = rd_ok ? mem[read_addr] : '0;
  // A hit implies both addresses are in range, so rd_word is the real stored word.
  assign rdw_hit = we && wr_ok && (write_addr == read_addr);

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NumBytes; i++) begin
      if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
  end

  assign rd_data = ((RDW_MODE == 1) && rdw_hit) ? merged : rd_word;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    q1_d    = q1_q;
    v1_d    = 1'b0;
    case (state_q)
      StInit: begin
        ptr_d = ptr_q + 1'b1;
        q1_d  = '0;
        if (ptr_q == LastAddr) state_d = StReady;
      end
      StReady: begin
        if (re) begin
          q1_d = rd_data;
          v1_d = 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      ptr_q   <= '0;
      q1_q    <= '0;
      v1_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      q1_q    <= q1_d;
      v1_q    <= v1_d;
      drop_q  <= (state_q == StInit) && (we || re);
    end
  end

  // Storage has no reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[ptr_q] <= '0;
    end else if (we && wr_ok) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (be[i]) mem[write_addr][8*i +: 8] <= data[8*i +: 8];
      end
    end
  end

`ifdef SYNC_RAM_OUT_REG_EN
  logic [DATA_W-1:0] q2_q;
  logic              v2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2_q <= '0;
      v2_q <= 1'b0;
    end else if (state_q == StInit) begin
      q2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      q2_q <= q1_q;
      v2_q <= v1_q;
    end
  end

  assign q       = q2_q;
  assign q_valid = v2_q;
`else
  assign q       = q1_q;
  assign q_valid = v1_q;
`endif

  assign init_done   = (state_q == StReady);
  assign req_dropped = drop_q;

endmodule

// File: tb/tb_sync_ram_be_init.sv
// Bench for sync_ram_be_init: three instances (old-data RDW, new-data RDW, DEPTH=48) on shared
// stimulus; a vector table feeds a latency-aware scoreboard, plus reset/INIT sequences.
module tb_sync_ram_be_init;

`ifdef SYNC_RAM_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [5:0]  write_addr, read_addr;
  logic [15:0] data;
  logic [1:0]  be;

  logic [15:0] q0, q1, q2;
  logic        v0, v1, v2;
  logic        done0, done1, done2;
  logic        drop0, drop1, drop2;

  always #5 clk = ~clk;

  sync_ram_be_init #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .write_addr(write_addr), .data(data), .be(be),
    .re(re), .read_addr(read_addr), .q(q0), .q_valid(v0), .init_done(done0),
    .req_dropped(drop0)
  );

  sync_ram_be_init #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .write_addr(write_addr), .data(data), .be(be),
    .re(re), .read_addr(read_addr), .q(q1), .q_valid(v1), .init_done(done1),
    .req_dropped(drop1)
  );

  sync_ram_be_init #(.DATA_W(16), .ADDR_W(6), .DEPTH(48), .RDW_MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .we(we), .write_addr(write_addr), .data(data), .be(be),
    .re(re), .read_addr(read_addr), .q(q2), .q_valid(v2), .init_done(done2),
    .req_dropped(drop2)
  );

  typedef struct {
    logic        w;
    logic [5:0]  wa;
    logic [15:0] d;
    logic [1:0]  b;
    logic        r;
    logic [5:0]  ra;
    logic [15:0] e0, e1, e2;
  } vec_t;

  typedef struct packed {
    logic [2:0][15:0] q;
    logic [2:0]       v;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last_e [3];
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl [19];

  function automatic vec_t mk(input logic w, input logic [5:0] wa, input logic [15:0] d,
                              input logic [1:0] b, input logic r, input logic [5:0] ra,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2);
    vec_t t;
    t.w = w; t.wa = wa; t.d = d; t.b = b; t.r = r; t.ra = ra;
    t.e0 = e0; t.e1 = e1; t.e2 = e2;
    return t;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic sb_reset();
    exp_t z;
    z = '0;
    sb.delete();
    for (int i = 0; i < 3; i++) last_e[i] = 16'h0;
    for (int i = 1; i < Lat; i++) sb.push_back(z);
  endtask

  // One READY-state cycle: push the expected stage result, compare what has reached q.
  task automatic tick(input vec_t t);
    exp_t        e, p;
    logic [15:0] eq [3];
    eq[0] = t.e0; eq[1] = t.e1; eq[2] = t.e2;
    we = t.w; write_addr = t.wa; data = t.d; be = t.b; re = t.r; read_addr = t.ra;
    for (int i = 0; i < 3; i++) begin
      if (t.r) last_e[i] = eq[i];
      e.q[i] = last_e[i];
      e.v[i] = t.r;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
    if (sb.size() >= Lat) begin
      p = sb.pop_front();
      check("q_rdw_old", q0, p.q[0]);
      check("q_rdw_new", q1, p.q[1]);
      check("q_depth48", q2, p.q[2]);
      check("q_valid_rdw_old", {15'h0, v0}, {15'h0, p.v[0]});
      check("q_valid_rdw_new", {15'h0, v1}, {15'h0, p.v[1]});
      check("q_valid_depth48", {15'h0, v2}, {15'h0, p.v[2]});
    end
  endtask

  // Counts posedges from reset release; optionally raises we on posedge drop_at.
  task automatic init_wait(input int n, input int drop_at);
    for (int k = 1; k <= n; k++) begin
      we = (k == drop_at);
      write_addr = 6'd5;
      data = 16'hBEEF;
      be = 2'b11;
      @(posedge clk);
      #1;
      we = 1'b0;
      check("init_done_d64", {15'h0, done0}, {15'h0, 1'(k >= 64)});
      check("init_done_d48", {15'h0, done2}, {15'h0, 1'(k >= 48)});
      check("req_dropped", {15'h0, drop0}, {15'h0, 1'(k == drop_at)});
      check("q_valid_in_init", {15'h0, v0}, 16'h0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check("rst_q", q0, 16'h0);
    check("rst_q_rdw_new", q1, 16'h0);
    check("rst_q_valid", {15'h0, v0}, 16'h0);
    check("rst_init_done", {15'h0, done0}, 16'h0);
    check("rst_req_dropped", {15'h0, drop0}, 16'h0);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(0, 6'd0,  16'h0000, 2'b00, 1, 6'd0,  16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, 6'd0,  16'h0000, 2'b00, 1, 6'd31, 16'h0000, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 6'd0,  16'h0000, 2'b00, 1, 6'd63, 16'h0000, 16'h0000, 16'h0000);
    tbl[3]  = mk(0, 6'd0,  16'h0000, 2'b00, 1, 6'd5,  16'h0000, 16'h0000, 16'h0000);
    tbl[4]  = mk(1, 6'd10, 16'h1234, 2'b11, 0, 6'd0,  16'h0000, 16'h0000, 16'h0000);
    tbl[5]  = mk(1, 6'd10, 16'hAB00, 2'b10, 0, 6'd0,  16'h0000, 16'h0000, 16'h0000);
    tbl[6]  = mk(0, 6'd0,  16'h0000, 2'b00, 1, 6'd10, 16'hAB34, 16'hAB34, 16'hAB34);
    tbl[7]  = mk(0, 6'd0,  16'h0000, 2'b00, 0, 6'd0,  16'h0000, 16'h0000, 16'h0000);
    tbl[8]  = mk(1, 6'd7,  16'h1111, 2'b11, 0, 6'd0,  16'h0000, 16'h0000, 16'h0000);
    tbl[9]  = mk(1, 6'd7,  16'h2222, 2'b01, 1, 6'd7,  16'h1111, 16'h1122, 16'h1111);
    tbl[10] = mk(0, 6'd0,  16'h0000, 2'b00, 1, 6'd7,  16'h1122, 16'h1122, 16'h1122);
    tbl[11] = mk(1, 6'd50, 16'hFFFF, 2'b11, 0, 6'd0,  16'h0000, 16'h0000, 16'h0000);
    tbl[12] = mk(0, 6'd0,  16'h0000, 2'b00, 1, 6'd50, 16'hFFFF, 16'hFFFF, 16'h0000);
    tbl[13] = mk(1, 6'd47, 16'hC3C3, 2'b11, 1, 6'd47, 16'h0000, 16'hC3C3, 16'h0000);
    tbl[14] = mk(0, 6'd0,  16'h0000, 2'b00, 1, 6'd47, 16'hC3C3, 16'hC3C3, 16'hC3C3);
    tbl[15] = mk(1, 6'd20, 16'h5678, 2'b01, 1, 6'd10, 16'hAB34, 16'hAB34, 16'hAB34);
    tbl[16] = mk(1, 6'd20, 16'h9A00, 2'b10, 1, 6'd20, 16'h0078, 16'h9A78, 16'h0078);
    tbl[17] = mk(1, 6'd20, 16'hFFFF, 2'b00, 1, 6'd20, 16'h9A78, 16'h9A78, 16'h9A78);
    tbl[18] = mk(0, 6'd0,  16'h0000, 2'b00, 1, 6'd63, 16'h0000, 16'h0000, 16'h0000);

    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; write_addr = '0; read_addr = '0; data = '0; be = '0;
    #3;
    check("por_q", q0, 16'h0);
    check("por_q_valid", {15'h0, v0}, 16'h0);
    check("por_init_done", {15'h0, done0}, 16'h0);
    #10;
    rst_n = 1'b1;

    // Full sweep with a write request dropped on the 3rd posedge.
    init_wait(64, 3);
    sb_reset();
    for (int i = 0; i < 19; i++) tick(tbl[i]);
    tick(mk(0, 6'd0, 16'h0, 2'b00, 0, 6'd0, 16'h0, 16'h0, 16'h0));

    tick(mk(1, 6'd3, 16'h5A5A, 2'b11, 0, 6'd0, 16'h0, 16'h0, 16'h0));
    tick(mk(0, 6'd0, 16'h0, 2'b00, 1, 6'd3, 16'h5A5A, 16'h5A5A, 16'h5A5A));
    tick(mk(0, 6'd0, 16'h0, 2'b00, 0, 6'd0, 16'h0, 16'h0, 16'h0));

    // Reset from READY, then again partway through the sweep (ptr=20).
    do_reset();
    init_wait(20, 0);
    do_reset();
    init_wait(64, 0);
    sb_reset();
    tick(mk(0, 6'd0, 16'h0, 2'b00, 1, 6'd3, 16'h0000, 16'h0000, 16'h0000));
    tick(mk(0, 6'd0, 16'h0, 2'b00, 1, 6'd10, 16'h0000, 16'h0000, 16'h0000));
    tick(mk(0, 6'd0, 16'h0, 2'b00, 0, 6'd0, 16'h0, 16'h0, 16'h0));
    check("req_dropped_ready", {15'h0, drop1}, 16'h0);
    check("init_done_rdw_new", {15'h0, done1}, 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
